pop_syn_sequencer: RTL and testbench
====================================

POP_SYN_SEQUENCER -- requirements
Module: pop_syn_sequencer

Interface
REQ-001 Parameter N_NUM, default 32, number of neurons (power of two, >=2).
REQ-002 Parameter G_NUM, default 4, receptive-field groups per neuron (power of two, >=2).
REQ-003 Parameter SPK_W, default 2, spike channels per window (1..N_NUM).
REQ-004 Derived N_SZ = clog2(N_NUM), G_SZ = clog2(G_NUM); never overridden.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rst  input  1  reset; asynchronous, active-high.
REQ-007 state  input  3  global phase code (IDLE 000, SET 001, SYN_ACCU 010, others ignored).
REQ-008 rf_setting  input  N_NUM*G_NUM  receptive-field table; bits [n*G_NUM +: G_NUM] = group code of neuron n.
REQ-009 win_valid  input  1  spike window offered.
REQ-010 rf_addr  input  N_SZ  base neuron index of offered window.
REQ-011 spike  input  SPK_W  spike mask; bit c = neuron (rf_addr+c) mod N_NUM.
REQ-012 sram_ready  input  1  synapse SRAM accepts the current access this cycle.
REQ-013 win_ready  output  1  sequencer can accept a window.
REQ-014 syn_addr  output  N_SZ+G_SZ  synapse address {neuron, group}.
REQ-015 sram_access  output  1  syn_addr valid; access issued when sram_access & sram_ready.
REQ-016 shift_en  output  1  one-cycle window-done pulse.
REQ-017 acc_cnt  output  clog2(SPK_W*G_NUM+1)  accesses completed in the last finished window.

Function
REQ-018 In state SET the table register SHALL load rf_setting every cycle; otherwise it holds.
REQ-019 FSM states: S_IDLE, S_ISSUE, S_DONE.
REQ-020 win_ready SHALL be 1 only in S_IDLE with state==SYN_ACCU.
REQ-021 win_valid & win_ready SHALL latch rf_addr, spike and the SPK_W group codes, then enter S_ISSUE (if any access is pending) or S_DONE (none).
REQ-022 In S_ISSUE, accesses are ordered by channel ascending, then group bit position ascending; only spiking channels with set code bits generate accesses.
REQ-023 The group field of syn_addr SHALL be the actual bit position of the set code bit, not a running count.
REQ-024 Neuron field = (base + c) mod N_NUM; wrap at N_NUM-1 -> 0.
REQ-025 First access SHALL appear the cycle after window acceptance; each further access the cycle after the previous one is accepted.
REQ-026 With sram_ready low, syn_addr and sram_access SHALL hold unchanged; no access skipped or repeated.
REQ-027 After the last accepted access, FSM enters S_DONE; shift_en SHALL be 1 for exactly that one cycle; FSM then returns to S_IDLE.
REQ-028 acc_cnt SHALL update in S_DONE to the number of accepted accesses of that window; holds otherwise.
REQ-029 If state leaves SYN_ACCU in any FSM state, FSM SHALL return to S_IDLE next cycle, sram_access 0, no shift_en pulse, acc_cnt unchanged.
REQ-030 syn_addr SHALL be 0 whenever sram_access is 0.

Reset
REQ-031 On rst: FSM S_IDLE; table, latched window, syn_addr, sram_access, shift_en, acc_cnt all 0; win_ready 0 until rst deasserts and state==SYN_ACCU.
REQ-032 rst mid-window SHALL abandon the window immediately; no access or pulse follows.

Structure
REQ-033 Shared package snn_pkg holds state codes (IDLE..DONE), default N_NUM/G_NUM/SPK_W, and FSM state typedef.
REQ-034 One sub-module lowest_set_idx (parametrised width, returns index and found flag) finds the next set channel and the next set group bit.

Verification (N_NUM=32, G_NUM=4, SPK_W=2)
REQ-035 rst pulse mid-operation -> all outputs 0 within same cycle; win_ready 1 only after rst low and state=010.
REQ-036 SET with neuron 5 code 1010, neuron 6 code 0001; window base 5, spike 11, sram_ready=1 -> syn_addr 0x15, 0x17, 0x18 on three consecutive cycles, then shift_en pulse, acc_cnt=3.
REQ-037 Window spike 00 (or all codes 0) -> no sram_access, shift_en at acceptance+1, acc_cnt=0.
REQ-038 Same as REQ-036 with sram_ready low 2 cycles on second access -> 0x17 held 3 cycles, sequence otherwise identical.
REQ-039 Base 31, spike 10, neuron 0 code 0100 -> single access syn_addr 0x02 (neuron wrap).
REQ-040 state changed to DECAY (011) during second access -> sram_access 0 next cycle, no shift_en, FSM S_IDLE.

Source files
------------

// File: rtl/pop_syn_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// snn_pkg : shared definitions for the SNN population/synapse pipeline.
//   - global phase codes driven on the 'state' bus
//   - default array dimensions (neurons, receptive-field groups, spike lanes)
//   - synapse-sequencer FSM state type
//   - idx_w(): index width for a one-hot/priority search over w bits
// ---------------------------------------------------------------------------
package snn_pkg;

  // Global phase codes
  localparam logic [2:0] ST_IDLE     = 3'b000;
  localparam logic [2:0] ST_SET      = 3'b001;
  localparam logic [2:0] ST_SYN_ACCU = 3'b010;
  localparam logic [2:0] ST_DECAY    = 3'b011;
  localparam logic [2:0] ST_DONE     = 3'b100;

  // Default dimensions
  localparam int N_NUM_DEF = 32;
  localparam int G_NUM_DEF = 4;
  localparam int SPK_W_DEF = 2;

  // Synapse sequencer FSM
  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_DONE  = 2'b10
  } seq_state_t;

  // Index width for a search over w bits; a 1-bit vector still needs a 1-bit index
  function automatic int idx_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/pop_syn_sequencer_if.sv
// ---------------------------------------------------------------------------
// pop_syn_sequencer_if : window-offer and synapse-SRAM handshake bundle.
//   win_valid / win_ready : spike window offer (rf_addr base, spike mask)
//   syn_addr / sram_access / sram_ready : synapse SRAM access handshake
// modport master : the controller side (offers windows, owns the SRAM)
// modport slave  : the sequencer side
// ---------------------------------------------------------------------------
interface pop_syn_sequencer_if
  import snn_pkg::*;
#(
  parameter int N_NUM = N_NUM_DEF,
  parameter int G_NUM = G_NUM_DEF,
  parameter int SPK_W = SPK_W_DEF
);
  localparam int N_SZ = $clog2(N_NUM);
  localparam int G_SZ = $clog2(G_NUM);

  logic                 win_valid;
  logic                 win_ready;
  logic [N_SZ-1:0]      rf_addr;
  logic [SPK_W-1:0]     spike;
  logic                 sram_ready;
  logic                 sram_access;
  logic [N_SZ+G_SZ-1:0] syn_addr;

  modport master (
    output win_valid,
    output rf_addr,
    output spike,
    output sram_ready,
    input  win_ready,
    input  sram_access,
    input  syn_addr
  );

  modport slave (
    input  win_valid,
    input  rf_addr,
    input  spike,
    input  sram_ready,
    output win_ready,
    output sram_access,
    output syn_addr
  );

endinterface

// File: rtl/pop_syn_sequencer_lowest_set_idx.sv
// ---------------------------------------------------------------------------
// lowest_set_idx : priority search for the lowest set bit of a vector.
//   vec   : input  WIDTH    bits to search
//   idx   : output IDX_W    position of the lowest set bit (0 when none)
//   found : output 1        at least one bit of vec is set
// ---------------------------------------------------------------------------
module lowest_set_idx
  import snn_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int IDX_W = idx_w(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // Scan from the top down so the last hit written is the lowest set bit
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end else begin
        idx   = idx;
        found = found;
      end
    end
  end

endmodule

// File: rtl/pop_syn_sequencer.sv
// ---------------------------------------------------------------------------
// pop_syn_sequencer : turns an accepted spike window into a stream of synapse
// SRAM accesses, one per (spiking channel, set receptive-field group bit).
//
// Ports
//   clk        input  1            clock, rising edge
//   rst        input  1            asynchronous active-high reset
//   state      input  3            global phase (SET loads table, SYN_ACCU runs)
//   rf_setting input  N_NUM*G_NUM  receptive-field group codes, G_NUM bits/neuron
//   bus        slave  modport      window offer + SRAM access handshake
//   shift_en   output 1            one-cycle pulse when a window is finished
//   acc_cnt    output ACC_W        accesses completed in the last finished window
//
// Accesses of a window are kept as a pending bitmask [channel][group]. Each
// cycle the lowest pending bit (channel first, then group) is the one that is
// presented next, so the order falls out of the search and the group field is
// always the real bit position of the code bit.
// ---------------------------------------------------------------------------
module pop_syn_sequencer
  import snn_pkg::*;
#(
  parameter  int N_NUM = N_NUM_DEF,
  parameter  int G_NUM = G_NUM_DEF,
  parameter  int SPK_W = SPK_W_DEF,
  localparam int N_SZ  = $clog2(N_NUM),
  localparam int G_SZ  = $clog2(G_NUM),
  localparam int ACC_W = $clog2(SPK_W * G_NUM + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2:0]             state,
  input  logic [N_NUM*G_NUM-1:0] rf_setting,
  pop_syn_sequencer_if.slave     bus,
  output logic                   shift_en,
  output logic [ACC_W-1:0]       acc_cnt
);

  localparam int CH_W = idx_w(SPK_W);

  seq_state_t                   fsm_r, fsm_n_s;
  logic [N_NUM*G_NUM-1:0]       table_r;
  logic [SPK_W-1:0][G_NUM-1:0]  pend_r, pend_n_s;
  logic [SPK_W-1:0][G_NUM-1:0]  new_mask_s, mask_src_s, pend_clr_s;
  logic [N_SZ-1:0]              base_r, base_n_s, base_src_s;
  logic [N_SZ+G_SZ-1:0]         syn_addr_r, syn_addr_n_s, next_addr_s;
  logic                         sram_access_r, sram_access_n_s;
  logic                         shift_en_r, shift_en_n_s;
  logic [ACC_W-1:0]             cnt_r, cnt_n_s;
  logic [ACC_W-1:0]             acc_cnt_r, acc_cnt_n_s;
  logic [SPK_W-1:0]             chan_any_s;
  logic [CH_W-1:0]              ch_idx_s;
  logic                         ch_found_s;
  logic [G_NUM-1:0]             grp_vec_s;
  logic [G_SZ-1:0]              grp_idx_s;
  logic                         grp_found_s;
  logic                         hit_s;
  logic                         in_accu_s, win_ready_s, accept_s, fire_s;

  assign in_accu_s   = (state == ST_SYN_ACCU);
  // Gated by rst so the window port stays closed while reset is held
  assign win_ready_s = ~rst & (fsm_r == S_IDLE) & in_accu_s;
  assign accept_s    = win_ready_s & bus.win_valid;
  assign fire_s      = sram_access_r & bus.sram_ready;

  // Receptive-field table: follows rf_setting during SET, frozen otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      table_r <= '0;
    end else if (state == ST_SET) begin
      table_r <= rf_setting;
    end else begin
      table_r <= table_r;
    end
  end

  // Access mask of the offered window: code of neuron (base+c) where channel c spikes
  always_comb begin
    logic [N_SZ-1:0] nrn_v;
    new_mask_s = '0;
    nrn_v      = '0;
    for (int c = 0; c < SPK_W; c++) begin
      nrn_v = bus.rf_addr + N_SZ'(c);
      if (bus.spike[c]) begin
        new_mask_s[c] = table_r[int'(nrn_v) * G_NUM +: G_NUM];
      end else begin
        new_mask_s[c] = '0;
      end
    end
  end

  // Search source: the fresh window on acceptance, else the remaining accesses
  always_comb begin
    if (accept_s) begin
      mask_src_s = new_mask_s;
      base_src_s = bus.rf_addr;
    end else begin
      mask_src_s = pend_r;
      base_src_s = base_r;
    end
  end

  // Channels with at least one access left
  always_comb begin
    chan_any_s = '0;
    for (int c = 0; c < SPK_W; c++) begin
      chan_any_s[c] = |mask_src_s[c];
    end
  end

  lowest_set_idx #(.WIDTH(SPK_W)) u_chan_sel (
    .vec   (chan_any_s),
    .idx   (ch_idx_s),
    .found (ch_found_s)
  );

  assign grp_vec_s = mask_src_s[ch_idx_s];

  lowest_set_idx #(.WIDTH(G_NUM)) u_grp_sel (
    .vec   (grp_vec_s),
    .idx   (grp_idx_s),
    .found (grp_found_s)
  );

  assign hit_s       = ch_found_s & grp_found_s;
  // Neuron field wraps naturally because the sum is truncated to N_SZ bits
  assign next_addr_s = {base_src_s + N_SZ'(ch_idx_s), grp_idx_s};

  // Remaining accesses once the selected one has been handed to the SRAM port
  always_comb begin
    pend_clr_s = mask_src_s;
    if (hit_s) begin
      pend_clr_s[ch_idx_s][grp_idx_s] = 1'b0;
    end else begin
      pend_clr_s = mask_src_s;
    end
  end

  // FSM next state and next values of all registered outputs
  always_comb begin
    fsm_n_s         = fsm_r;
    pend_n_s        = pend_r;
    base_n_s        = base_r;
    syn_addr_n_s    = syn_addr_r;
    sram_access_n_s = sram_access_r;
    shift_en_n_s    = 1'b0;
    cnt_n_s         = cnt_r;
    acc_cnt_n_s     = acc_cnt_r;
    case (fsm_r)
      S_IDLE: begin
        if (accept_s) begin
          base_n_s = bus.rf_addr;
          cnt_n_s  = '0;
          if (hit_s) begin
            fsm_n_s         = S_ISSUE;
            pend_n_s        = pend_clr_s;
            syn_addr_n_s    = next_addr_s;
            sram_access_n_s = 1'b1;
          end else begin
            // Nothing to fetch: finish the window right away
            fsm_n_s      = S_DONE;
            pend_n_s     = '0;
            shift_en_n_s = 1'b1;
            acc_cnt_n_s  = '0;
          end
        end else begin
          fsm_n_s = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (!in_accu_s) begin
          // Phase left SYN_ACCU: drop the window without a done pulse
          fsm_n_s         = S_IDLE;
          pend_n_s        = '0;
          syn_addr_n_s    = '0;
          sram_access_n_s = 1'b0;
        end else if (fire_s) begin
          cnt_n_s = cnt_r + ACC_W'(1);
          if (hit_s) begin
            pend_n_s     = pend_clr_s;
            syn_addr_n_s = next_addr_s;
          end else begin
            fsm_n_s         = S_DONE;
            pend_n_s        = '0;
            syn_addr_n_s    = '0;
            sram_access_n_s = 1'b0;
            shift_en_n_s    = 1'b1;
            acc_cnt_n_s     = cnt_r + ACC_W'(1);
          end
        end else begin
          // SRAM stalled: keep presenting the same access
          fsm_n_s = S_ISSUE;
        end
      end
      S_DONE: begin
        fsm_n_s = S_IDLE;
      end
      default: begin
        fsm_n_s         = S_IDLE;
        pend_n_s        = '0;
        syn_addr_n_s    = '0;
        sram_access_n_s = 1'b0;
      end
    endcase
  end

  // FSM state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_r         <= S_IDLE;
      pend_r        <= '0;
      base_r        <= '0;
      syn_addr_r    <= '0;
      sram_access_r <= 1'b0;
      shift_en_r    <= 1'b0;
      cnt_r         <= '0;
      acc_cnt_r     <= '0;
    end else begin
      fsm_r         <= fsm_n_s;
      pend_r        <= pend_n_s;
      base_r        <= base_n_s;
      syn_addr_r    <= syn_addr_n_s;
      sram_access_r <= sram_access_n_s;
      shift_en_r    <= shift_en_n_s;
      cnt_r         <= cnt_n_s;
      acc_cnt_r     <= acc_cnt_n_s;
    end
  end

  assign bus.win_ready   = win_ready_s;
  assign bus.syn_addr    = syn_addr_r;
  assign bus.sram_access = sram_access_r;
  assign shift_en        = shift_en_r;
  assign acc_cnt         = acc_cnt_r;

endmodule

// File: tb/tb_pop_syn_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pop_syn_sequencer : self-checking bench for pop_syn_sequencer
// (N_NUM=32, G_NUM=4, SPK_W=2). Directed vector table, hand-written corner
// sequences (stall, phase abort, reset abort) and random windows checked
// against an access-list model built from the receptive-field rules.
// ---------------------------------------------------------------------------
module tb_pop_syn_sequencer;
  import snn_pkg::*;

  localparam int N_NUM = 32;
  localparam int G_NUM = 4;
  localparam int SPK_W = 2;
  localparam int ACC_W = $clog2(SPK_W * G_NUM + 1);

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [2:0]             state = ST_IDLE;
  logic [N_NUM*G_NUM-1:0] rf_setting = '0;
  logic                   shift_en;
  logic [ACC_W-1:0]       acc_cnt;

  pop_syn_sequencer_if #(.N_NUM(N_NUM), .G_NUM(G_NUM), .SPK_W(SPK_W)) bus ();

  pop_syn_sequencer #(.N_NUM(N_NUM), .G_NUM(G_NUM), .SPK_W(SPK_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .state      (state),
    .rf_setting (rf_setting),
    .bus        (bus),
    .shift_en   (shift_en),
    .acc_cnt    (acc_cnt)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         last_cnt = 0;
  logic [6:0] exp_q[$];

  typedef struct {
    logic [4:0]       base;
    logic [1:0]       spike;
    logic [3:0]       code0;   // group code of neuron base
    logic [3:0]       code1;   // group code of neuron base+1
    int               cnt;
    logic [0:7][6:0]  addr;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic load_table(input logic [N_NUM*G_NUM-1:0] tbl);
    @(posedge clk); #1;
    state      = ST_SET;
    rf_setting = tbl;
    @(posedge clk); #1;
    state      = ST_IDLE;
    rf_setting = ~tbl;   // must not be picked up outside SET
  endtask

  function automatic logic [N_NUM*G_NUM-1:0] make_table(input logic [4:0] base,
                                                        input logic [3:0] c0,
                                                        input logic [3:0] c1);
    logic [N_NUM*G_NUM-1:0] t;
    int n1;
    t  = {$urandom, $urandom, $urandom, $urandom};
    n1 = (int'(base) + 1) % N_NUM;
    t[int'(base)*G_NUM +: G_NUM] = c0;
    t[n1*G_NUM +: G_NUM]         = c1;
    return t;
  endfunction

  // Reference: every set code bit of every spiking channel, channel then group order
  task automatic build_exp(input logic [N_NUM*G_NUM-1:0] tbl, input logic [4:0] base,
                           input logic [1:0] spk);
    int n;
    exp_q.delete();
    for (int c = 0; c < SPK_W; c++) begin
      n = (int'(base) + c) % N_NUM;
      for (int g = 0; g < G_NUM; g++) begin
        if (spk[c] && tbl[n*G_NUM + g]) exp_q.push_back(7'(n*G_NUM + g));
      end
    end
  endtask

  // Offer one window and follow it to the done pulse, cycle by cycle
  task automatic run_window(input string tag, input logic [4:0] base, input logic [1:0] spk,
                            input int stall_idx, input int stall_len, input bit rnd);
    int   total, k, stalls;
    bit   done;
    logic ready;
    total = exp_q.size(); k = 0; stalls = 0; done = 1'b0;
    @(posedge clk); #1;
    state = ST_SYN_ACCU; bus.win_valid = 1'b1; bus.rf_addr = base; bus.spike = spk;
    bus.sram_ready = 1'b1;
    @(negedge clk);
    check({tag, "_win_ready"}, 32'(bus.win_ready), 32'd1);
    @(posedge clk); #1;
    bus.win_valid = 1'b0; bus.spike = 2'b00;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      if (rnd) ready = ($urandom_range(0, 3) != 0);
      else if (k == stall_idx && stalls < stall_len) ready = 1'b0;
      else ready = 1'b1;
      bus.sram_ready = ready;
      @(negedge clk);
      if (exp_q.size() > 0) begin
        check({tag, "_access"}, 32'(bus.sram_access), 32'd1);
        check({tag, "_addr"}, 32'(bus.syn_addr), 32'(exp_q[0]));
        check({tag, "_no_shift"}, 32'(shift_en), 32'd0);
        if (ready) begin
          void'(exp_q.pop_front());
          k++;
        end else if (k == stall_idx) begin
          stalls++;
        end
      end else begin
        check({tag, "_done_access"}, 32'(bus.sram_access), 32'd0);
        check({tag, "_done_addr"}, 32'(bus.syn_addr), 32'd0);
        check({tag, "_shift"}, 32'(shift_en), 32'd1);
        check({tag, "_acc_cnt"}, 32'(acc_cnt), 32'(total));
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: actual=no shift_en required=shift_en within 200 cycles", tag);
    end
    @(negedge clk);
    check({tag, "_pulse_end"}, 32'(shift_en), 32'd0);
    check({tag, "_acc_hold"}, 32'(acc_cnt), 32'(total));
    check({tag, "_ready_again"}, 32'(bus.win_ready), 32'd1);
    last_cnt = total;
  endtask

  // Offer the REQ-036 window and stop once the second access is on the port
  task automatic start_to_second_access();
    load_table(make_table(5'd5, 4'b1010, 4'b0001));
    @(posedge clk); #1;
    state = ST_SYN_ACCU; bus.win_valid = 1'b1; bus.rf_addr = 5'd5; bus.spike = 2'b11;
    bus.sram_ready = 1'b1;
    @(posedge clk); #1;
    bus.win_valid = 1'b0; bus.spike = 2'b00;
    @(negedge clk);
    check("abort_first_addr", 32'(bus.syn_addr), 32'h15);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [N_NUM*G_NUM-1:0] tbl;
    logic [4:0] rb;
    logic [1:0] rs;

    vecs[0] = '{base:5'd5,  spike:2'b11, code0:4'b1010, code1:4'b0001, cnt:3,
                addr:{7'h15, 7'h17, 7'h18, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00}};
    vecs[1] = '{base:5'd5,  spike:2'b00, code0:4'b1010, code1:4'b0001, cnt:0, addr:'0};
    vecs[2] = '{base:5'd12, spike:2'b11, code0:4'b0000, code1:4'b0000, cnt:0, addr:'0};
    vecs[3] = '{base:5'd31, spike:2'b10, code0:4'b1111, code1:4'b0100, cnt:1,
                addr:{7'h02, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00}};
    vecs[4] = '{base:5'd31, spike:2'b11, code0:4'b1000, code1:4'b0001, cnt:2,
                addr:{7'h7F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00}};
    vecs[5] = '{base:5'd10, spike:2'b01, code0:4'b1111, code1:4'b0000, cnt:4,
                addr:{7'h28, 7'h29, 7'h2A, 7'h2B, 7'h00, 7'h00, 7'h00, 7'h00}};
    vecs[6] = '{base:5'd0,  spike:2'b11, code0:4'b1111, code1:4'b1111, cnt:8,
                addr:{7'h00, 7'h01, 7'h02, 7'h03, 7'h04, 7'h05, 7'h06, 7'h07}};
    vecs[7] = '{base:5'd20, spike:2'b10, code0:4'b0110, code1:4'b1001, cnt:2,
                addr:{7'h54, 7'h57, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00}};

    bus.win_valid = 1'b0; bus.rf_addr = '0; bus.spike = '0; bus.sram_ready = 1'b0;
    state = ST_SYN_ACCU;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_win_ready", 32'(bus.win_ready), 32'd0);
    check("rst_access", 32'(bus.sram_access), 32'd0);
    check("rst_addr", 32'(bus.syn_addr), 32'd0);
    check("rst_shift", 32'(shift_en), 32'd0);
    check("rst_acc_cnt", 32'(acc_cnt), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_win_ready", 32'(bus.win_ready), 32'd1);

    // No acceptance outside SYN_ACCU
    @(posedge clk); #1;
    state = ST_IDLE; bus.win_valid = 1'b1; bus.spike = 2'b11;
    @(negedge clk);
    check("idle_win_ready", 32'(bus.win_ready), 32'd0);
    @(posedge clk); #1;
    bus.win_valid = 1'b0; bus.spike = 2'b00;
    @(negedge clk);
    check("idle_no_access", 32'(bus.sram_access), 32'd0);
    check("idle_no_shift", 32'(shift_en), 32'd0);

    // Directed vector table
    for (int i = 0; i < 8; i++) begin
      load_table(make_table(vecs[i].base, vecs[i].code0, vecs[i].code1));
      exp_q.delete();
      for (int k = 0; k < vecs[i].cnt; k++) exp_q.push_back(vecs[i].addr[k]);
      run_window($sformatf("vec%0d", i), vecs[i].base, vecs[i].spike, -1, 0, 1'b0);
    end

    // SRAM stall of two cycles on the second access
    load_table(make_table(5'd5, 4'b1010, 4'b0001));
    exp_q.delete();
    exp_q.push_back(7'h15); exp_q.push_back(7'h17); exp_q.push_back(7'h18);
    run_window("stall", 5'd5, 2'b11, 1, 2, 1'b0);

    // Phase change to DECAY while the second access is pending
    start_to_second_access();
    state = ST_DECAY; bus.sram_ready = 1'b0;
    @(negedge clk);
    check("decay_second_addr", 32'(bus.syn_addr), 32'h17);
    check("decay_second_access", 32'(bus.sram_access), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("decay_access_off", 32'(bus.sram_access), 32'd0);
    check("decay_addr_zero", 32'(bus.syn_addr), 32'd0);
    check("decay_no_shift", 32'(shift_en), 32'd0);
    check("decay_acc_hold", 32'(acc_cnt), 32'(last_cnt));
    @(posedge clk); #1;
    state = ST_SYN_ACCU;
    @(negedge clk);
    check("decay_no_shift_late", 32'(shift_en), 32'd0);
    check("decay_back_idle", 32'(bus.win_ready), 32'd1);

    // Reset in the middle of a window
    start_to_second_access();
    rst = 1'b1;
    #1;
    check("midrst_access", 32'(bus.sram_access), 32'd0);
    check("midrst_addr", 32'(bus.syn_addr), 32'd0);
    check("midrst_shift", 32'(shift_en), 32'd0);
    check("midrst_acc_cnt", 32'(acc_cnt), 32'd0);
    check("midrst_win_ready", 32'(bus.win_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_ready_after", 32'(bus.win_ready), 32'd1);
    check("midrst_no_access", 32'(bus.sram_access), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst_no_pulse", 32'(shift_en), 32'd0);
    check("midrst_no_access2", 32'(bus.sram_access), 32'd0);
    last_cnt = 0;

    // Random windows with random SRAM back-pressure
    for (int r = 0; r < 40; r++) begin
      tbl = {$urandom, $urandom, $urandom, $urandom};
      rb  = 5'($urandom_range(0, N_NUM - 1));
      rs  = 2'($urandom_range(0, 3));
      load_table(tbl);
      build_exp(tbl, rb, rs);
      run_window($sformatf("rnd%0d", r), rb, rs, -1, 0, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
